// File: rtl/upc_sequencer.sv
// upc_sequencer: micro-program counter with next-address sequencing and a return-address stack
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   en             advance enable (0 holds every piece of state)
//   op, cond       sequencing op and datapath branch condition
//   target         jump/branch/call destination from the current microword
//   back_val       upc - 2 from the external subtract-by-2 stage
//   upc            current micro-address
//   stack_empty    return stack holds no entries
//   stack_full     return stack holds DEPTH entries
//   err            sticky fault from CALL on full or RET on empty
module upc_sequencer #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             cond,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] back_val,
    output logic [WIDTH-1:0] upc,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] SP_FULL = (AW + 1)'(DEPTH);
    localparam logic [2:0] OP_NEXT  = 3'd0;
    localparam logic [2:0] OP_JUMP  = 3'd1;
    localparam logic [2:0] OP_BRT   = 3'd2;
    localparam logic [2:0] OP_BRF   = 3'd3;
    localparam logic [2:0] OP_CALL  = 3'd4;
    localparam logic [2:0] OP_RET   = 3'd5;
    localparam logic [2:0] OP_BACK2 = 3'd6;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [AW:0]      sp, sp_n, sp_dec;
    logic [WIDTH-1:0] upc_n, upc_inc, top;
    logic             push, fault;

    assign upc_inc = upc + WIDTH'(1);
    assign sp_dec  = sp - (AW + 1)'(1);
    assign top     = stack[sp_dec[AW-1:0]];

    always_comb begin
        upc_n = upc;
        sp_n  = sp;
        push  = 1'b0;
        fault = 1'b0;
        case (op)
            OP_NEXT:  upc_n = upc_inc;
            OP_JUMP:  upc_n = target;
            OP_BRT:   upc_n = cond ? target : upc_inc;
            OP_BRF:   upc_n = cond ? upc_inc : target;
            OP_CALL: begin
                fault = stack_full;
                push  = !stack_full;
                sp_n  = stack_full ? sp : sp + (AW + 1)'(1);
                upc_n = stack_full ? upc : target;
            end
            OP_RET: begin
                fault = stack_empty;
                sp_n  = stack_empty ? sp : sp_dec;
                upc_n = stack_empty ? upc : top;
            end
            OP_BACK2: upc_n = back_val;
            default:  upc_n = upc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc         <= RESET_ADDR;
            sp          <= '0;
            err         <= 1'b0;
            stack_empty <= 1'b1;
            stack_full  <= 1'b0;
        end else if (en) begin
            upc         <= upc_n;
            sp          <= sp_n;
            err         <= err | fault;
            stack_empty <= sp_n == '0;
            stack_full  <= sp_n == SP_FULL;
        end
    end

    // Stack storage needs no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && en && push)
            stack[sp[AW-1:0]] <= upc_inc;
    end
endmodule

// File: tb/tb_upc_sequencer.sv
// tb_upc_sequencer: scoreboard bench for upc_sequencer using directed vectors
module tb_upc_sequencer;
    localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BRT = 3'd2, BRF = 3'd3,
                           CALL = 3'd4, RET = 3'd5, BACK2 = 3'd6, HOLD = 3'd7;

    typedef struct {
        int          id;
        logic [10:0] upc;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  op = NEXT;
    logic        cond = 1'b0;
    logic [10:0] target = '0;
    logic [10:0] back_val;
    logic [10:0] upc;
    logic        stack_empty, stack_full, err;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;
    int   pushed = 0;

    // Model of the external subtract-by-2 stage.
    assign back_val = upc - 11'd2;

    upc_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .cond(cond), .target(target),
        .back_val(back_val), .upc(upc), .stack_empty(stack_empty),
        .stack_full(stack_full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic [2:0] o, input logic c,
                        input logic [10:0] t, input logic [10:0] x_upc,
                        input logic x_empty, input logic x_full, input logic x_err);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; op = o; cond = c; target = t;
        @(posedge clk);
        #1;
        x.id = pushed; x.upc = x_upc; x.empty = x_empty; x.full = x_full; x.err = x_err;
        exp_q.push_back(x);
        pushed++;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            if (upc !== x.upc || stack_empty !== x.empty || stack_full !== x.full || err !== x.err) begin
                fails++;
                $display("FAIL step%0d: got upc=%0d empty=%b full=%b err=%b, expected upc=%0d empty=%b full=%b err=%b",
                         x.id, upc, stack_empty, stack_full, err, x.upc, x.empty, x.full, x.err);
            end
        end
    end

    initial begin
        // reset, sequential, wrap
        step(1, 1, NEXT, 0, 0,    0,    1, 0, 0);
        step(0, 1, NEXT, 1, 0,    1,    1, 0, 0);
        step(0, 1, NEXT, 0, 0,    2,    1, 0, 0);
        step(0, 1, NEXT, 0, 0,    3,    1, 0, 0);
        step(0, 1, JUMP, 0, 2047, 2047, 1, 0, 0);
        step(0, 1, NEXT, 0, 0,    0,    1, 0, 0);
        step(0, 1, JUMP, 0, 5,    5,    1, 0, 0);
        step(1, 1, JUMP, 0, 9,    0,    1, 0, 0);
        // conditional branches
        step(0, 1, JUMP, 0, 10,   10,   1, 0, 0);
        step(0, 1, BRT,  1, 200,  200,  1, 0, 0);
        step(0, 1, JUMP, 0, 10,   10,   1, 0, 0);
        step(0, 1, BRT,  0, 200,  11,   1, 0, 0);
        step(0, 1, JUMP, 0, 10,   10,   1, 0, 0);
        step(0, 1, BRF,  1, 200,  11,   1, 0, 0);
        step(0, 1, BRF,  0, 200,  200,  1, 0, 0);
        // single call/return
        step(0, 1, JUMP, 0, 20,   20,   1, 0, 0);
        step(0, 1, CALL, 0, 100,  100,  0, 0, 0);
        step(0, 1, RET,  1, 0,    21,   1, 0, 0);
        // nested calls to full, overflow, drain, underflow
        step(0, 1, JUMP, 0, 30,   30,   1, 0, 0);
        step(0, 1, CALL, 0, 100,  100,  0, 0, 0);
        step(0, 1, CALL, 0, 110,  110,  0, 0, 0);
        step(0, 1, CALL, 0, 120,  120,  0, 0, 0);
        step(0, 1, CALL, 0, 300,  300,  0, 1, 0);
        step(0, 1, CALL, 0, 500,  300,  0, 1, 1);
        step(0, 1, RET,  0, 0,    121,  0, 0, 1);
        step(0, 1, RET,  0, 0,    111,  0, 0, 1);
        step(0, 1, RET,  0, 0,    101,  0, 0, 1);
        step(0, 1, RET,  0, 0,    31,   1, 0, 1);
        step(0, 1, RET,  0, 0,    31,   1, 0, 1);
        step(0, 1, HOLD, 1, 9,    31,   1, 0, 1);
        // BACK2 through the subtract-by-2 model
        step(0, 1, JUMP, 0, 50,   50,   1, 0, 1);
        step(0, 1, BACK2,0, 0,    48,   1, 0, 1);
        step(0, 1, JUMP, 0, 1,    1,    1, 0, 1);
        step(0, 1, BACK2,0, 0,    2047, 1, 0, 1);
        step(0, 1, JUMP, 0, 0,    0,    1, 0, 1);
        step(0, 1, BACK2,0, 0,    2046, 1, 0, 1);
        // stall with a live stack entry
        step(0, 1, CALL, 0, 40,   40,   0, 0, 1);
        step(0, 0, JUMP, 0, 7,    40,   0, 0, 1);
        step(0, 0, JUMP, 0, 7,    40,   0, 0, 1);
        step(0, 0, RET,  0, 7,    40,   0, 0, 1);
        step(0, 1, JUMP, 0, 7,    7,    0, 0, 1);
        step(0, 1, RET,  0, 0,    2047, 1, 0, 1);
        // CALL pushes a wrapped return address
        step(0, 1, CALL, 0, 60,   60,   0, 0, 1);
        step(0, 1, RET,  0, 0,    0,    1, 0, 1);
        // reset clears err and discards the stack mid-sequence, even with en low
        step(0, 1, CALL, 0, 70,   70,   0, 0, 1);
        step(1, 0, RET,  0, 0,    0,    1, 0, 0);
        step(0, 1, RET,  0, 0,    0,    1, 0, 1);
        step(1, 1, NEXT, 0, 0,    0,    1, 0, 0);
        step(0, 1, NEXT, 0, 0,    1,    1, 0, 0);
        begin : drain
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 10) begin
                @(posedge clk);
                n++;
            end
            @(posedge clk);
        end
        if (exp_q.size() != 0 || checks != pushed) begin
            fails++;
            $display("FAIL scoreboard_drain: checked=%0d pending=%0d, expected checked=%0d pending=0",
                     checks, exp_q.size(), pushed);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
